// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: state encoding, debug view, counter sizing.
package div_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

    // r_msb is the top bit of the partial remainder; it should never be set.
    typedef struct packed {
        state_t state;
        logic   r_msb;
    } dbg_t;

    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v = value - 1;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell; chained to form the trial-subtraction borrow path.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes on input and output.
// Handshake: a transfer happens on a rising edge where valid && ready; one operation in flight.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output dbg_t             dbg
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH:0]   part_r;
    logic [WIDTH-1:0] work_q;
    logic [CW-1:0]    count;
    logic             zero_q;

    logic [WIDTH:0]   s_val;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   t_val;
    logic [WIDTH+1:0] brw;
    logic             no_borrow;
    logic [WIDTH:0]   next_r;
    logic [WIDTH-1:0] next_q;

    assign s_val = {part_r[WIDTH-1:0], work_q[WIDTH-1]};
    assign sub_b = {1'b0, div_q};
    assign brw[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i <= WIDTH; i++) begin : g_sub
            full_subtractor u_fs (
                .a   (s_val[i]),
                .b   (sub_b[i]),
                .bin (brw[i]),
                .diff(t_val[i]),
                .bout(brw[i+1])
            );
        end
    endgenerate

    assign no_borrow = ~brw[WIDTH+1];
    assign next_r    = no_borrow ? t_val : s_val;
    assign next_q    = {work_q[WIDTH-2:0], no_borrow};

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = RUN;
            end
            // A zero divisor spends exactly one cycle here so its result lands one edge after accept.
            RUN: begin
                if (zero_q || count == LAST) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div_q       <= '0;
            part_r      <= '0;
            work_q      <= '0;
            count       <= '0;
            zero_q      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        div_q  <= divisor;
                        part_r <= '0;
                        work_q <= dividend;
                        count  <= '0;
                        zero_q <= (divisor == '0);
                    end
                end
                RUN: begin
                    if (zero_q) begin
                        quotient    <= '1;
                        remainder   <= work_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        part_r <= next_r;
                        work_q <= next_q;
                        count  <= count + 1'b1;
                        // Result registers only move on the final step so they hold across the next run.
                        if (count == LAST) begin
                            quotient    <= next_q;
                            remainder   <= next_r[WIDTH-1:0];
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg.state = state;
    assign dbg.r_msb = part_r[WIDTH];

endmodule

// File: tb/tb_restoring_divider.sv
// Directed table, backpressure, reset-abort and random scoreboard checks for restoring_divider.
module tb_restoring_divider;
    import div_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    dbg_t         dbg;

    logic [2*W:0] exp_q[$];
    int           n_vec;
    int           n_err;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[10];

    restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .dbg        (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Drives one operation, checks latency, stalls the consumer for 'hold' cycles, then completes it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W:0] expect_word, input int hold);
        int           guard;
        int           lat;
        logic [2*W:0] e;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_op", {31'd0, in_ready}, 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        exp_q.push_back(expect_word);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, (b == '0) ? 32'd1 : 32'd8);
        if (!out_valid) return;
        e = exp_q.pop_front();
        chk("quotient", {24'd0, quotient}, {24'd0, e[2*W-1:W]});
        chk("remainder", {24'd0, remainder}, {24'd0, e[W-1:0]});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[2*W]});
        if (b != '0) begin
            chk("inv_sum", quotient * b + remainder, {24'd0, a});
            chk("inv_rem_lt_div", {31'd0, remainder < b}, 32'd1);
        end
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            dividend = W'($urandom_range(0, 255));
            divisor  = W'($urandom_range(1, 255));
            @(negedge clk);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_result", {15'd0, div_by_zero, quotient, remainder}, {15'd0, e});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_hs_hold", {15'd0, div_by_zero, quotient, remainder}, {15'd0, e});
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2*W:0] rexp;
        int           seen;

        n_vec     = 0;
        n_err     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        rst_n     = 1'b0;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        vecs[3] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[4] = '{8'd200, 8'd0,   8'd255, 8'd200, 1'b1};
        vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        vecs[6] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};
        vecs[7] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
        vecs[8] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
        vecs[9] = '{8'd254, 8'd127, 8'd2,   8'd0,   1'b0};

        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_outputs", {15'd0, div_by_zero, quotient, remainder}, 32'd0);
        chk("reset_state", {30'd0, dbg.state}, {30'd0, S_IDLE});
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++)
            run_op(vecs[v].a, vecs[v].b, {vecs[v].z, vecs[v].q, vecs[v].r}, 0);

        // Backpressure: five stalled cycles with a competing request that must be dropped.
        run_op(8'd100, 8'd7, {1'b0, 8'd14, 8'd2}, 5);
        run_op(8'd50, 8'd5, {1'b0, 8'd10, 8'd0}, 0);

        // Reset during iteration 4 abandons the operation.
        dividend = 8'd100;
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_run_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_outputs", {15'd0, div_by_zero, quotient, remainder}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 32'd0);

        for (int n = 0; n < 2000; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            if (rb == '0) rexp = {1'b1, 8'hFF, ra};
            else          rexp = {1'b0, ra / rb, ra % rb};
            run_op(ra, rb, rexp, $urandom_range(0, 3));
        end

        chk("r_msb_clear", {31'd0, dbg.r_msb}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
